vx_barrier_unit: RTL and testbench

//  Receiver for barrier_t requests issued by the warp-control (SFU) path. Tracks warp arrivals per barrier id, holds

---
 rtl/vx_barrier_unit_pkg.sv | 34 +++
 rtl/vx_barrier_unit_prio_enc.sv | 28 ++
 rtl/vx_barrier_unit.sv | 170 +++++++++++++++++
 tb/tb_vx_barrier_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vx_barrier_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_barrier_unit_pkg
// Description : Shared types and default sizing for the core barrier unit.
// Revision    : 1.0 - initial release
// ============================================================================
package vx_barrier_unit_pkg;

    localparam int c_num_warps_def    = 8;
    localparam int c_num_barriers_def = 4;
    localparam int c_num_cores_def    = 4;
    localparam int c_nw_width_def     = $clog2(c_num_warps_def);
    localparam int c_nb_width_def     = $clog2(c_num_barriers_def);
    localparam int c_nc_width_def     = $clog2(c_num_cores_def);
    localparam int c_gsize_w_def      = (c_nw_width_def > c_nc_width_def) ? c_nw_width_def : c_nc_width_def;

    typedef enum logic [1:0] {
        BAR_IDLE  = 2'd0,
        BAR_COUNT = 2'd1,
        BAR_GSEND = 2'd2,
        BAR_GWAIT = 2'd3
    } bar_state_e;

    typedef struct packed {
        logic [c_nb_width_def-1:0] id;
        logic [c_gsize_w_def-1:0]  size_m1;
    } gbar_req_t;

    typedef struct packed {
        logic [c_nb_width_def-1:0] id;
    } gbar_rsp_t;

endpackage
`default_nettype wire

// File: rtl/vx_barrier_unit_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : vx_barrier_unit_prio_enc
// Description : Lowest-index-wins priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_barrier_unit_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vx_barrier_unit.sv
`default_nettype none
// ============================================================================
// Module      : vx_barrier_unit
// Description : Per-id barrier table: parks arriving warps, releases them on
//               local completion or on the cluster global-barrier response.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_barrier_unit
    import vx_barrier_unit_pkg::*;
#(
    parameter int NUM_WARPS    = c_num_warps_def,
    parameter int NUM_BARRIERS = c_num_barriers_def,
    parameter int GSIZE_W      = c_gsize_w_def,
    parameter int NW_WIDTH     = $clog2(NUM_WARPS),
    parameter int NB_WIDTH     = $clog2(NUM_BARRIERS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [NW_WIDTH-1:0]  req_wid,
    input  logic [NB_WIDTH-1:0]  req_id,
    input  logic                 req_is_global,
    input  logic [GSIZE_W-1:0]   req_size_m1,
    input  logic [NUM_WARPS-1:0] active_wmask,
    output logic [NUM_WARPS-1:0] stall_mask,
    output logic                 release_valid,
    output logic [NUM_WARPS-1:0] release_mask,
    output logic                 gbar_req_valid,
    output logic [NB_WIDTH-1:0]  gbar_req_id,
    output logic [GSIZE_W-1:0]   gbar_req_size_m1,
    input  logic                 gbar_req_ready,
    input  logic                 gbar_rsp_valid,
    input  logic [NB_WIDTH-1:0]  gbar_rsp_id
);

    bar_state_e           r_state   [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]  r_count   [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] r_mask    [NUM_BARRIERS];
    logic [GSIZE_W-1:0]   r_size_m1 [NUM_BARRIERS];
    logic                 r_global  [NUM_BARRIERS];

    logic [NUM_WARPS-1:0] r_stall_mask;
    logic                 r_release_valid;
    logic [NUM_WARPS-1:0] r_release_mask;
    logic                 r_gbar_valid;
    logic [NB_WIDTH-1:0]  r_gbar_id;
    logic [GSIZE_W-1:0]   r_gbar_size_m1;

    logic [NUM_WARPS-1:0]    w_req_bit;
    logic [NUM_WARPS-1:0]    w_nmask;
    logic                    w_req_legal;
    logic                    w_local_done;
    logic                    w_global_full;
    logic                    w_rsp_hit;
    logic                    w_gbar_fire;
    logic [NUM_WARPS-1:0]    w_arrive;
    logic [NUM_WARPS-1:0]    w_rel_mask;
    logic [NUM_BARRIERS-1:0] w_gsend_vec;
    logic [NB_WIDTH-1:0]     w_enc_idx;
    logic                    w_enc_valid;

    assign w_req_bit = NUM_WARPS'(1) << req_wid;
    assign w_nmask   = r_mask[req_id] | w_req_bit;

    // An entry accepts arrivals only while idle or counting arrivals of the same kind.
    assign w_req_legal = req_valid
                      && ((r_state[req_id] == BAR_IDLE)
                       || ((r_state[req_id] == BAR_COUNT) && (r_global[req_id] == req_is_global)));

    assign w_local_done  = w_req_legal && !req_is_global
                        && (r_count[req_id] == req_size_m1[NW_WIDTH-1:0]);
    assign w_global_full = w_req_legal && req_is_global && (w_nmask == active_wmask);
    assign w_rsp_hit     = gbar_rsp_valid && (r_state[gbar_rsp_id] == BAR_GWAIT);
    assign w_gbar_fire   = r_gbar_valid && gbar_req_ready;

    assign w_arrive   = w_req_legal ? w_req_bit : '0;
    assign w_rel_mask = (w_local_done ? w_nmask : '0)
                      | (w_rsp_hit ? r_mask[gbar_rsp_id] : '0);

    generate
        for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_gsend
            assign w_gsend_vec[b] = (r_state[b] == BAR_GSEND);
        end
    endgenerate

    vx_barrier_unit_prio_enc #(
        .N     (NUM_BARRIERS),
        .IDX_W (NB_WIDTH)
    ) u_gsend_sel (
        .req   (w_gsend_vec),
        .idx   (w_enc_idx),
        .valid (w_enc_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                r_state[b]   <= BAR_IDLE;
                r_count[b]   <= '0;
                r_mask[b]    <= '0;
                r_size_m1[b] <= '0;
                r_global[b]  <= 1'b0;
            end
            r_stall_mask    <= '0;
            r_release_valid <= 1'b0;
            r_release_mask  <= '0;
            r_gbar_valid    <= 1'b0;
            r_gbar_id       <= '0;
            r_gbar_size_m1  <= '0;
        end else begin
            r_stall_mask    <= (r_stall_mask | w_arrive) & ~w_rel_mask;
            r_release_valid <= |w_rel_mask;
            r_release_mask  <= w_rel_mask;

            if (w_req_legal) begin
                if (req_is_global) begin
                    r_mask[req_id]    <= w_nmask;
                    r_global[req_id]  <= 1'b1;
                    r_size_m1[req_id] <= req_size_m1;
                    r_state[req_id]   <= w_global_full ? BAR_GSEND : BAR_COUNT;
                end else if (w_local_done) begin
                    r_state[req_id]  <= BAR_IDLE;
                    r_count[req_id]  <= '0;
                    r_mask[req_id]   <= '0;
                    r_global[req_id] <= 1'b0;
                end else begin
                    r_state[req_id]  <= BAR_COUNT;
                    r_count[req_id]  <= r_count[req_id] + 1'b1;
                    r_mask[req_id]   <= w_nmask;
                    r_global[req_id] <= 1'b0;
                end
            end

            // A GWAIT entry can never also be the target of a legal request.
            if (w_rsp_hit) begin
                r_state[gbar_rsp_id]  <= BAR_IDLE;
                r_count[gbar_rsp_id]  <= '0;
                r_mask[gbar_rsp_id]   <= '0;
                r_global[gbar_rsp_id] <= 1'b0;
            end

            if (w_gbar_fire) begin
                r_state[r_gbar_id] <= BAR_GWAIT;
                r_gbar_valid       <= 1'b0;
            end else if (!r_gbar_valid && w_enc_valid) begin
                r_gbar_valid   <= 1'b1;
                r_gbar_id      <= w_enc_idx;
                r_gbar_size_m1 <= r_size_m1[w_enc_idx];
            end
        end
    end

    assign stall_mask       = r_stall_mask;
    assign release_valid    = r_release_valid;
    assign release_mask     = r_release_mask;
    assign gbar_req_valid   = r_gbar_valid;
    assign gbar_req_id      = r_gbar_id;
    assign gbar_req_size_m1 = r_gbar_size_m1;

    a_no_restall : assert property (@(posedge clk) disable iff (!reset)
        req_valid |-> !r_stall_mask[req_wid]);

    a_legal_entry : assert property (@(posedge clk) disable iff (!reset)
        req_valid |-> w_req_legal);

    a_local_size : assert property (@(posedge clk) disable iff (!reset)
        (req_valid && !req_is_global) |-> ({1'b0, req_size_m1} < (GSIZE_W + 1)'(NUM_WARPS)));

endmodule
`default_nettype wire

// File: tb/tb_vx_barrier_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_barrier_unit
// Description : Directed vector table plus hand sequences for the barrier unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_barrier_unit;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_wid;
    logic [1:0] req_id;
    logic       req_is_global;
    logic [2:0] req_size_m1;
    logic [7:0] active_wmask;
    logic [7:0] stall_mask;
    logic       release_valid;
    logic [7:0] release_mask;
    logic       gbar_req_valid;
    logic [1:0] gbar_req_id;
    logic [2:0] gbar_req_size_m1;
    logic       gbar_req_ready;
    logic       gbar_rsp_valid;
    logic [1:0] gbar_rsp_id;

    int n_tests = 0;
    int n_fail  = 0;

    vx_barrier_unit dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_wid          (req_wid),
        .req_id           (req_id),
        .req_is_global    (req_is_global),
        .req_size_m1      (req_size_m1),
        .active_wmask     (active_wmask),
        .stall_mask       (stall_mask),
        .release_valid    (release_valid),
        .release_mask     (release_mask),
        .gbar_req_valid   (gbar_req_valid),
        .gbar_req_id      (gbar_req_id),
        .gbar_req_size_m1 (gbar_req_size_m1),
        .gbar_req_ready   (gbar_req_ready),
        .gbar_rsp_valid   (gbar_rsp_valid),
        .gbar_rsp_id      (gbar_rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rv;
        logic [2:0] wid;
        logic [1:0] id;
        logic       glob;
        logic [2:0] sz;
        logic [7:0] act;
        logic       rdy;
        logic       rspv;
        logic [1:0] rspid;
        logic [7:0] e_stall;
        logic       e_rv;
        logic [7:0] e_rm;
        logic       e_gv;
        logic [1:0] e_gid;
        logic [2:0] e_gsz;
    } vec_t;

    function automatic vec_t mk(input logic rv, input logic [2:0] wid, input logic [1:0] id,
                                input logic glob, input logic [2:0] sz, input logic [7:0] act,
                                input logic rdy, input logic rspv, input logic [1:0] rspid,
                                input logic [7:0] e_stall, input logic e_rv, input logic [7:0] e_rm,
                                input logic e_gv, input logic [1:0] e_gid, input logic [2:0] e_gsz);
        vec_t v;
        v.rv = rv; v.wid = wid; v.id = id; v.glob = glob; v.sz = sz; v.act = act;
        v.rdy = rdy; v.rspv = rspv; v.rspid = rspid;
        v.e_stall = e_stall; v.e_rv = e_rv; v.e_rm = e_rm;
        v.e_gv = e_gv; v.e_gid = e_gid; v.e_gsz = e_gsz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are driven #1 after a rising edge, consumed by the next edge, and
    // the registered outputs are checked #1 after that edge.
    task automatic apply(input string tag, input vec_t v);
        req_valid      = v.rv;
        req_wid        = v.wid;
        req_id         = v.id;
        req_is_global  = v.glob;
        req_size_m1    = v.sz;
        active_wmask   = v.act;
        gbar_req_ready = v.rdy;
        gbar_rsp_valid = v.rspv;
        gbar_rsp_id    = v.rspid;
        @(posedge clk);
        #1;
        chk({tag, " stall_mask"}, 32'(stall_mask), 32'(v.e_stall));
        chk({tag, " release_valid"}, 32'(release_valid), 32'(v.e_rv));
        chk({tag, " release_mask"}, 32'(release_mask), 32'(v.e_rm));
        chk({tag, " gbar_req_valid"}, 32'(gbar_req_valid), 32'(v.e_gv));
        if (v.e_gv) begin
            chk({tag, " gbar_req_id"}, 32'(gbar_req_id), 32'(v.e_gid));
            chk({tag, " gbar_req_size_m1"}, 32'(gbar_req_size_m1), 32'(v.e_gsz));
        end
    endtask

    vec_t vecs [18];
    vec_t idle;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                rv wid  id  g  sz  act   rdy rsp rid  stall rv  rm    gv gid gsz
        vecs[0]  = mk(1, 3'd0, 2'd0, 0, 3'd3, 8'h00, 0, 0, 2'd0, 8'h01, 0, 8'h00, 0, 2'd0, 3'd0);
        vecs[1]  = mk(1, 3'd1, 2'd0, 0, 3'd3, 8'h00, 0, 0, 2'd0, 8'h03, 0, 8'h00, 0, 2'd0, 3'd0);
        vecs[2]  = mk(1, 3'd2, 2'd0, 0, 3'd3, 8'h00, 0, 0, 2'd0, 8'h07, 0, 8'h00, 0, 2'd0, 3'd0);
        vecs[3]  = mk(1, 3'd3, 2'd0, 0, 3'd3, 8'h00, 0, 0, 2'd0, 8'h00, 1, 8'h0F, 0, 2'd0, 3'd0);
        vecs[4]  = mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h00, 0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 2'd0, 3'd0);
        vecs[5]  = mk(1, 3'd2, 2'd1, 0, 3'd0, 8'h00, 0, 0, 2'd0, 8'h00, 1, 8'h04, 0, 2'd0, 3'd0);
        vecs[6]  = mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h00, 0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 2'd0, 3'd0);
        vecs[7]  = mk(1, 3'd0, 2'd1, 1, 3'd3, 8'h03, 0, 0, 2'd0, 8'h01, 0, 8'h00, 0, 2'd0, 3'd0);
        vecs[8]  = mk(1, 3'd1, 2'd1, 1, 3'd3, 8'h03, 0, 0, 2'd0, 8'h03, 0, 8'h00, 0, 2'd0, 3'd0);
        vecs[9]  = mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h03, 0, 0, 2'd0, 8'h03, 0, 8'h00, 1, 2'd1, 3'd3);
        vecs[10] = mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h03, 0, 0, 2'd0, 8'h03, 0, 8'h00, 1, 2'd1, 3'd3);
        vecs[11] = mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h03, 0, 0, 2'd0, 8'h03, 0, 8'h00, 1, 2'd1, 3'd3);
        vecs[12] = mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h03, 0, 0, 2'd0, 8'h03, 0, 8'h00, 1, 2'd1, 3'd3);
        vecs[13] = mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h03, 0, 0, 2'd0, 8'h03, 0, 8'h00, 1, 2'd1, 3'd3);
        vecs[14] = mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h03, 1, 0, 2'd0, 8'h03, 0, 8'h00, 0, 2'd0, 3'd0);
        vecs[15] = mk(1, 3'd4, 2'd3, 0, 3'd1, 8'h03, 0, 0, 2'd0, 8'h13, 0, 8'h00, 0, 2'd0, 3'd0);
        vecs[16] = mk(1, 3'd5, 2'd3, 0, 3'd1, 8'h03, 0, 1, 2'd1, 8'h00, 1, 8'h33, 0, 2'd0, 3'd0);
        vecs[17] = mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h00, 0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 2'd0, 3'd0);
        idle     = mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h00, 0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 2'd0, 3'd0);

        reset          = 1'b0;
        req_valid      = 1'b0;
        req_wid        = '0;
        req_id         = '0;
        req_is_global  = 1'b0;
        req_size_m1    = '0;
        active_wmask   = '0;
        gbar_req_ready = 1'b0;
        gbar_rsp_valid = 1'b0;
        gbar_rsp_id    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset stall_mask", 32'(stall_mask), 32'h0);
        chk("reset release_valid", 32'(release_valid), 32'h0);
        chk("reset release_mask", 32'(release_mask), 32'h0);
        chk("reset gbar_req_valid", 32'(gbar_req_valid), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            apply($sformatf("v%0d", i), vecs[i]);
        end

        // Two globals in GSEND are offered in index order; responses arrive out of order.
        apply("g0 arrive", mk(1, 3'd2, 2'd0, 1, 3'd1, 8'h04, 0, 0, 2'd0, 8'h04, 0, 8'h00, 0, 2'd0, 3'd0));
        apply("g2 arrive", mk(1, 3'd3, 2'd2, 1, 3'd1, 8'h08, 0, 0, 2'd0, 8'h0C, 0, 8'h00, 1, 2'd0, 3'd1));
        apply("g0 hold",   mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h08, 0, 0, 2'd0, 8'h0C, 0, 8'h00, 1, 2'd0, 3'd1));
        apply("g0 accept", mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h08, 1, 0, 2'd0, 8'h0C, 0, 8'h00, 0, 2'd0, 3'd0));
        apply("g2 offer",  mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h08, 0, 0, 2'd0, 8'h0C, 0, 8'h00, 1, 2'd2, 3'd1));
        apply("g2 accept", mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h08, 1, 0, 2'd0, 8'h0C, 0, 8'h00, 0, 2'd0, 3'd0));
        apply("g2 rsp",    mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h00, 0, 1, 2'd2, 8'h04, 1, 8'h08, 0, 2'd0, 3'd0));
        apply("g0 rsp",    mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h00, 0, 1, 2'd0, 8'h00, 1, 8'h04, 0, 2'd0, 3'd0));
        apply("g idle",    idle);

        // Reset while id0 counts (mask 0x5) and id1 waits on the cluster.
        apply("r l0",      mk(1, 3'd0, 2'd0, 0, 3'd3, 8'h00, 0, 0, 2'd0, 8'h01, 0, 8'h00, 0, 2'd0, 3'd0));
        apply("r l2",      mk(1, 3'd2, 2'd0, 0, 3'd3, 8'h00, 0, 0, 2'd0, 8'h05, 0, 8'h00, 0, 2'd0, 3'd0));
        apply("r g1",      mk(1, 3'd1, 2'd1, 1, 3'd3, 8'h02, 0, 0, 2'd0, 8'h07, 0, 8'h00, 0, 2'd0, 3'd0));
        apply("r offer",   mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h02, 1, 0, 2'd0, 8'h07, 0, 8'h00, 1, 2'd1, 3'd3));
        apply("r accept",  mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h02, 1, 0, 2'd0, 8'h07, 0, 8'h00, 0, 2'd0, 3'd0));
        reset = 1'b0;
        apply("r assert",  idle);
        reset = 1'b1;
        apply("r stale rsp", mk(0, 3'd0, 2'd0, 0, 3'd0, 8'h00, 0, 1, 2'd1, 8'h00, 0, 8'h00, 0, 2'd0, 3'd0));
        apply("r reuse id0", mk(1, 3'd1, 2'd0, 0, 3'd0, 8'h00, 0, 0, 2'd0, 8'h00, 1, 8'h02, 0, 2'd0, 3'd0));
        apply("r idle",    idle);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
